// File: rtl/food_spawner_if.sv
// Occupancy query handshake between the food spawner (master) and the snake-body store (slave).
interface food_spawner_if;
   logic       occ_req;
   logic [6:0] occ_x;
   logic [6:0] occ_y;
   logic       occ_ack;
   logic       occ_hit;

   modport master (output occ_req, output occ_x, output occ_y, input occ_ack, input occ_hit);
   modport slave  (input occ_req, input occ_x, input occ_y, output occ_ack, output occ_hit);
endinterface

// File: rtl/food_spawner.sv
// Draws random grid coordinates from the LFSR stream, checks occupancy with the snake
// store and publishes a free cell as the new food position.
module food_spawner #(
   parameter int GRID_W    = 40,
   parameter int GRID_H    = 30,
   parameter int MAX_TRIES = 8
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [6:0]            Random_Data,
   input  logic                  spawn_req,
   output logic                  busy,
   food_spawner_if.master        occ,
   output logic                  food_valid,
   output logic [6:0]            food_x,
   output logic [6:0]            food_y,
   output logic                  spawn_done,
   output logic                  spawn_fail
);
   localparam int TRY_W = $clog2(MAX_TRIES + 1);
   localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);
   localparam logic [6:0] W_LIM = 7'(GRID_W);
   localparam logic [6:0] H_LIM = 7'(GRID_H);

   typedef enum logic [2:0] {IDLE, GET_X, GET_Y, QUERY, COMMIT} state_t;

   state_t           state_q, state_d;
   logic [6:0]       cand_x_q, cand_x_d, cand_y_q, cand_y_d;
   logic [6:0]       food_x_q, food_x_d, food_y_q, food_y_d;
   logic [6:0]       occ_x_q, occ_x_d, occ_y_q, occ_y_d;
   logic             food_valid_q, food_valid_d;
   logic             occ_req_q, occ_req_d;
   logic             spawn_done_q, spawn_done_d;
   logic             spawn_fail_q, spawn_fail_d;
   logic [TRY_W-1:0] tries_q, tries_d;
   logic [6:0]       cand;

   // LFSR never emits 0, so the shifted value spans 0..126; 0 wraps to 127 and is rejected.
   assign cand = Random_Data - 7'd1;

   always_comb begin
      state_d      = state_q;
      cand_x_d     = cand_x_q;
      cand_y_d     = cand_y_q;
      food_x_d     = food_x_q;
      food_y_d     = food_y_q;
      food_valid_d = food_valid_q;
      occ_req_d    = occ_req_q;
      occ_x_d      = occ_x_q;
      occ_y_d      = occ_y_q;
      tries_d      = tries_q;
      spawn_done_d = 1'b0;
      spawn_fail_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (spawn_req) begin
               state_d      = GET_X;
               food_valid_d = 1'b0;
               tries_d      = '0;
            end
         end
         GET_X: begin
            if (cand < W_LIM) begin
               cand_x_d = cand;
               state_d  = GET_Y;
            end
         end
         GET_Y: begin
            if (cand < H_LIM) begin
               cand_y_d  = cand;
               state_d   = QUERY;
               occ_req_d = 1'b1;
               occ_x_d   = cand_x_q;
               occ_y_d   = cand;
            end
         end
         QUERY: begin
            if (occ.occ_ack) begin
               occ_req_d = 1'b0;
               if (!occ.occ_hit) begin
                  state_d      = COMMIT;
                  spawn_done_d = 1'b1;
               end else if (tries_q == LAST_TRY) begin
                  state_d      = IDLE;
                  spawn_fail_d = 1'b1;
               end else begin
                  tries_d = tries_q + TRY_W'(1);
                  state_d = GET_X;
               end
            end
         end
         COMMIT: begin
            food_x_d     = cand_x_q;
            food_y_d     = cand_y_q;
            food_valid_d = 1'b1;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q      <= IDLE;
         cand_x_q     <= '0;
         cand_y_q     <= '0;
         food_x_q     <= '0;
         food_y_q     <= '0;
         food_valid_q <= 1'b0;
         occ_req_q    <= 1'b0;
         occ_x_q      <= '0;
         occ_y_q      <= '0;
         tries_q      <= '0;
         spawn_done_q <= 1'b0;
         spawn_fail_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cand_x_q     <= cand_x_d;
         cand_y_q     <= cand_y_d;
         food_x_q     <= food_x_d;
         food_y_q     <= food_y_d;
         food_valid_q <= food_valid_d;
         occ_req_q    <= occ_req_d;
         occ_x_q      <= occ_x_d;
         occ_y_q      <= occ_y_d;
         tries_q      <= tries_d;
         spawn_done_q <= spawn_done_d;
         spawn_fail_q <= spawn_fail_d;
      end
   end

   assign busy        = (state_q != IDLE);
   assign occ.occ_req = occ_req_q;
   assign occ.occ_x   = occ_x_q;
   assign occ.occ_y   = occ_y_q;
   assign food_valid  = food_valid_q;
   assign food_x      = food_x_q;
   assign food_y      = food_y_q;
   assign spawn_done  = spawn_done_q;
   assign spawn_fail  = spawn_fail_q;
endmodule
